// File: rtl/ahb_req_arbiter.sv
// Two-channel round-robin AHB-Lite master front end issuing SINGLE/INCR halfword bursts.
// Optional ARB_LOCK_EN adds lock0/lock1 to hold the grant and drive HMASTLOCK.
module ahb_req_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  HCLK,
  input  logic                  RESET,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  write0,
  input  logic [2:0]            len0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  wack0,
  output logic                  rvalid0,
  output logic                  done0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  write1,
  input  logic [2:0]            len1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  wack1,
  output logic                  rvalid1,
  output logic                  done1,
`ifdef ARB_LOCK_EN
  input  logic                  lock0,
  input  logic                  lock1,
`endif
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HBURST,
  output logic [2:0]            HSIZE,
  output logic                  HWRITE,
  output logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;
  localparam logic [2:0] MAXB      = 3'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_LAST,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic [2:0]            len_q, len_d;
  logic [2:0]            beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [2:0]            hburst_q, hburst_d;
  logic                  hwrite_q, hwrite_d;
  logic                  dphase_q, dphase_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [1:0]            done_q, done_d;
  logic                  err_q, err_d;
`ifdef ARB_LOCK_EN
  logic                  lock_q, lock_d;
  logic                  mlock_q, mlock_d;
  logic                  sel_lock;
`endif

  logic                  go;
  logic                  sel;
  logic [2:0]            sel_len;
  logic [2:0]            sel_eff;
  logic                  xfer_ok;
  logic                  data_err;

  function automatic logic [2:0] eff_len(input logic [2:0] l);
    if (l == 3'd0) begin
      return 3'd1;
    end else if (l > MAXB) begin
      return MAXB;
    end else begin
      return l;
    end
  endfunction

  // gnt_q resets to 1 so a simultaneous request after reset goes to ch0
  always_comb begin
    go  = req0 | req1;
    sel = (req0 & req1) ? ~gnt_q : req1;
`ifdef ARB_LOCK_EN
    if (lock_q) begin
      sel = gnt_q;
      go  = gnt_q ? req1 : req0;
    end
    sel_lock = sel ? lock1 : lock0;
`endif
    sel_len = sel ? len1 : len0;
    sel_eff = eff_len(sel_len);
  end

  assign xfer_ok  = dphase_q & HREADY & ~HRESP;
  assign data_err = dphase_q & HRESP;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    len_d    = len_q;
    beat_d   = beat_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hburst_d = hburst_q;
    hwrite_d = hwrite_q;
    dphase_d = dphase_q;
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;
    done_d   = 2'b00;
    err_d    = 1'b0;
`ifdef ARB_LOCK_EN
    lock_d   = lock_q;
    mlock_d  = mlock_q;
`endif

    if (xfer_ok & ~hwrite_q) begin
      rdata_d         = HRDATA;
      rvalid_d[gnt_q] = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        htrans_d = HT_IDLE;
        dphase_d = 1'b0;
        if (go) begin
          gnt_d    = sel;
          len_d    = sel_eff;
          beat_d   = 3'd0;
          haddr_d  = sel ? addr1 : addr0;
          hwrite_d = sel ? write1 : write0;
          htrans_d = HT_NONSEQ;
          hburst_d = (sel_eff == 3'd1) ? HB_SINGLE : HB_INCR;
          state_d  = S_ADDR;
`ifdef ARB_LOCK_EN
          mlock_d  = lock_q | sel_lock;
          lock_d   = sel_lock;
`endif
        end
      end
      S_ADDR: begin
        if (data_err) begin
          htrans_d       = HT_IDLE;
          dphase_d       = 1'b0;
          done_d[gnt_q]  = 1'b1;
          err_d          = 1'b1;
          state_d        = S_DONE;
`ifdef ARB_LOCK_EN
          mlock_d        = 1'b0;
`endif
        end else if (HREADY) begin
          dphase_d = 1'b1;
          if (beat_q == len_q - 3'd1) begin
            htrans_d = HT_IDLE;
            state_d  = S_LAST;
`ifdef ARB_LOCK_EN
            mlock_d  = 1'b0;
`endif
          end else begin
            beat_d   = beat_q + 3'd1;
            haddr_d  = haddr_q + ADDR_WIDTH'(1);
            htrans_d = HT_SEQ;
          end
        end
      end
      S_LAST: begin
        if (data_err || HREADY) begin
          dphase_d      = 1'b0;
          done_d[gnt_q] = 1'b1;
          err_d         = data_err;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        htrans_d = HT_IDLE;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b1;
      len_q    <= 3'd1;
      beat_q   <= 3'd0;
      haddr_q  <= '0;
      htrans_q <= HT_IDLE;
      hburst_q <= HB_SINGLE;
      hwrite_q <= 1'b0;
      dphase_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_q   <= 1'b0;
      mlock_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hburst_q <= hburst_d;
      hwrite_q <= hwrite_d;
      dphase_q <= dphase_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef ARB_LOCK_EN
      lock_q   <= lock_d;
      mlock_q  <= mlock_d;
`endif
    end
  end

  // write data and its acknowledge follow the slave's ready in the data phase
  assign wack0  = dphase_q & hwrite_q & ~gnt_q & HREADY & ~HRESP;
  assign wack1  = dphase_q & hwrite_q &  gnt_q & HREADY & ~HRESP;
  assign HWDATA = (dphase_q & hwrite_q) ? (gnt_q ? wdata1 : wdata0) : '0;

  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign done0   = done_q[0];
  assign done1   = done_q[1];
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign HADDR   = haddr_q;
  assign HTRANS  = htrans_q;
  assign HBURST  = hburst_q;
  assign HSIZE   = 3'b001;
  assign HWRITE  = hwrite_q;
`ifdef ARB_LOCK_EN
  assign HMASTLOCK = mlock_q;
`else
  assign HMASTLOCK = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Scoreboard bench for ahb_req_arbiter with a small AHB RAM slave model.
// Expected address phases and channel responses are queued; a monitor pops them.
module tb_ahb_req_arbiter;

  localparam int EV_WACK = 0;
  localparam int EV_RV   = 1;
  localparam int EV_DONE = 2;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;
  localparam logic [2:0] SG = 3'b000;
  localparam logic [2:0] IC = 3'b001;

  logic HCLK = 1'b0;
  logic RESET = 1'b1;
  int   cyc = 0;

  logic        req   [2];
  logic [15:0] addr  [2];
  logic        wr    [2];
  logic [2:0]  len   [2];
  logic [15:0] wdata [2];
  logic [1:0]  wack, rvalid, done;
  logic [15:0] rdata;
  logic        err;
  logic [15:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST, HSIZE;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;

  ahb_req_arbiter dut (
    .HCLK(HCLK), .RESET(RESET),
    .req0(req[0]), .addr0(addr[0]), .write0(wr[0]),
    .len0(len[0]), .wdata0(wdata[0]),
    .wack0(wack[0]), .rvalid0(rvalid[0]), .done0(done[0]),
    .req1(req[1]), .addr1(addr[1]), .write1(wr[1]),
    .len1(len[1]), .wdata1(wdata[1]),
    .wack1(wack[1]), .rvalid1(rvalid[1]), .done1(done[1]),
`ifdef ARB_LOCK_EN
    .lock0(1'b0), .lock1(1'b0),
`endif
    .rdata(rdata), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HMASTLOCK(HMASTLOCK), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  // slave model
  logic [15:0] mem [0:65535];
  logic        d_valid = 1'b0;
  logic        d_write = 1'b0;
  logic [15:0] d_addr = '0;
  int          stall_cnt = 0;
  int          stall_tgt = 0;
  logic        err_en = 1'b0;
  logic [15:0] err_addr = '0;
  logic        err_stage = 1'b0;
  logic        stall, errc;

  always_comb begin
    stall  = (HTRANS == NS) && (stall_cnt < stall_tgt);
    errc   = d_valid && err_en && (d_addr == err_addr);
    HRESP  = errc;
    HREADY = !stall && !(errc && !err_stage);
    HRDATA = d_valid ? mem[d_addr] : 16'h0;
  end

  always @(posedge HCLK) begin
    if (stall) stall_cnt <= stall_cnt + 1;
    err_stage <= errc && !err_stage;
    if (HREADY && d_valid && d_write && !HRESP)
      mem[d_addr] <= HWDATA;
    if (HREADY) begin
      d_valid <= HTRANS[1];
      d_addr  <= HADDR;
      d_write <= HWRITE;
    end
  end

  // scoreboard
  typedef struct {
    int          kind;
    int          ch;
    logic [15:0] data;
    int          c;
  } ev_t;
  typedef struct {
    logic [15:0] a;
    logic [1:0]  t;
    logic [2:0]  b;
    logic        w;
    int          c;
  } ap_t;

  ev_t evq[$];
  ap_t apq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic ap(input logic [15:0] a, input logic [1:0] t,
                    input logic [2:0] b, input logic w, input int c);
    ap_t x;
    x.a = a; x.t = t; x.b = b; x.w = w; x.c = c;
    apq.push_back(x);
  endtask

  task automatic ev(input int k, input int ch, input logic [15:0] d,
                    input int c);
    ev_t x;
    x.kind = k; x.ch = ch; x.data = d; x.c = c;
    evq.push_back(x);
  endtask

  task automatic pop_ev(input int k, input int ch, input logic [15:0] d);
    ev_t x;
    if (evq.size() == 0) begin
      chk($sformatf("unexpected_ev k%0d ch%0d", k, ch), 1, 0);
    end else begin
      x = evq.pop_front();
      chk("ev_kind_ch", 32'(k * 2 + ch), 32'(x.kind * 2 + x.ch));
      chk($sformatf("ev_data k%0d", k), {16'h0, d}, {16'h0, x.data});
      if (x.c >= 0) chk("ev_cycle", 32'(cyc), 32'(x.c));
    end
  endtask

  always @(negedge HCLK) begin
    if (RESET) begin
      if (HTRANS[1] && HREADY) begin
        if (apq.size() == 0) begin
          chk("unexpected_addr_phase", {16'h0, HADDR}, 32'hFFFFFFFF);
        end else begin
          ap_t x;
          x = apq.pop_front();
          chk("haddr", {16'h0, HADDR}, {16'h0, x.a});
          chk("htrans", {30'h0, HTRANS}, {30'h0, x.t});
          chk("hburst", {29'h0, HBURST}, {29'h0, x.b});
          chk("hwrite", {31'h0, HWRITE}, {31'h0, x.w});
          if (x.c >= 0) chk("addr_cycle", 32'(cyc), 32'(x.c));
        end
      end
      for (int k = 0; k < 2; k++)
        if (wack[k]) pop_ev(EV_WACK, k, HWDATA);
      for (int k = 0; k < 2; k++)
        if (rvalid[k]) pop_ev(EV_RV, k, rdata);
      for (int k = 0; k < 2; k++)
        if (done[k]) pop_ev(EV_DONE, k, {15'h0, err});
    end
  end

  task automatic run_cmd(input int ch, input logic [15:0] a,
                         input logic w, input logic [2:0] l,
                         input logic [15:0] d0, input logic [15:0] d1);
    logic [15:0] wd [2];
    int idx;
    int n;
    bit fin;
    wd[0] = d0; wd[1] = d1;
    idx = 0; n = 0; fin = 1'b0;
    addr[ch] = a; wr[ch] = w; len[ch] = l;
    wdata[ch] = wd[0]; req[ch] = 1'b1;
    while (!fin && n < 60) begin
      @(negedge HCLK);
      n++;
      if (done[ch]) begin
        fin = 1'b1;
        req[ch] = 1'b0;
      end else if (wack[ch]) begin
        @(posedge HCLK);
        #1;
        idx++;
        if (idx < 2) wdata[ch] = wd[idx];
      end
    end
    req[ch] = 1'b0;
    chk($sformatf("done_seen ch%0d", ch), {31'h0, fin}, 1);
  endtask

  task automatic rst_chk();
    chk("rst_htrans", {30'h0, HTRANS}, 0);
    chk("rst_haddr", {16'h0, HADDR}, 0);
    chk("rst_hburst", {29'h0, HBURST}, 0);
    chk("rst_hsize", {29'h0, HSIZE}, 1);
    chk("rst_hwrite", {31'h0, HWRITE}, 0);
    chk("rst_hwdata", {16'h0, HWDATA}, 0);
    chk("rst_hmastlock", {31'h0, HMASTLOCK}, 0);
    chk("rst_pulses", {26'h0, wack, rvalid, done}, 0);
    chk("rst_err", {31'h0, err}, 0);
    chk("rst_rdata", {16'h0, rdata}, 0);
  endtask

  int t0;

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; addr[k] = '0; wr[k] = 1'b0;
      len[k] = '0; wdata[k] = '0;
    end
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[3] = 16'd40; mem[4] = 16'd50; mem[5] = 16'd60;
    mem[6] = 16'h0066;
    mem[16'h20] = 16'h1111; mem[16'h21] = 16'h2222;
    mem[16'h30] = 16'h3030;
    #1 RESET = 1'b0;
    repeat (2) @(negedge HCLK);
    rst_chk();
    RESET = 1'b1;
    repeat (2) @(negedge HCLK);

    // 1: single write, latency
    t0 = cyc;
    ap(16'h0010, NS, SG, 1'b1, t0 + 1);
    ev(EV_WACK, 0, 16'hBEEF, t0 + 2);
    ev(EV_DONE, 0, 16'h0, t0 + 3);
    run_cmd(0, 16'h0010, 1'b1, 3'd1, 16'hBEEF, 16'h0);
    repeat (2) @(negedge HCLK);
    chk("mem_0010", {16'h0, mem[16'h10]}, 32'hBEEF);

    // 2: read burst of 3
    t0 = cyc;
    ap(16'h0003, NS, IC, 1'b0, t0 + 1);
    ap(16'h0004, SQ, IC, 1'b0, t0 + 2);
    ap(16'h0005, SQ, IC, 1'b0, t0 + 3);
    ev(EV_RV, 1, 16'd40, t0 + 3);
    ev(EV_RV, 1, 16'd50, t0 + 4);
    ev(EV_RV, 1, 16'd60, t0 + 5);
    ev(EV_DONE, 1, 16'h0, t0 + 5);
    run_cmd(1, 16'h0003, 1'b0, 3'd3, 16'h0, 16'h0);
    repeat (2) @(negedge HCLK);

    // 3: simultaneous requests, ch0 first then ch1 after gap
    t0 = cyc;
    ap(16'h0040, NS, SG, 1'b1, t0 + 1);
    ev(EV_WACK, 0, 16'h1234, t0 + 2);
    ev(EV_DONE, 0, 16'h0, t0 + 3);
    ap(16'h0010, NS, SG, 1'b0, t0 + 5);
    ev(EV_RV, 1, 16'hBEEF, t0 + 7);
    ev(EV_DONE, 1, 16'h0, t0 + 7);
    fork
      run_cmd(0, 16'h0040, 1'b1, 3'd1, 16'h1234, 16'h0);
      run_cmd(1, 16'h0010, 1'b0, 3'd1, 16'h0, 16'h0);
    join
    repeat (2) @(negedge HCLK);
    chk("mem_0040", {16'h0, mem[16'h40]}, 32'h1234);

    // 4: wrap at 0xFFFF with two wait states on beat 0
    stall_tgt = stall_cnt + 2;
    t0 = cyc;
    ap(16'hFFFF, NS, IC, 1'b1, t0 + 3);
    ap(16'h0000, SQ, IC, 1'b1, t0 + 4);
    ev(EV_WACK, 0, 16'hA5A5, t0 + 4);
    ev(EV_WACK, 0, 16'h5A5A, t0 + 5);
    ev(EV_DONE, 0, 16'h0, t0 + 6);
    run_cmd(0, 16'hFFFF, 1'b1, 3'd2, 16'hA5A5, 16'h5A5A);
    repeat (2) @(negedge HCLK);
    chk("mem_ffff", {16'h0, mem[16'hFFFF]}, 32'hA5A5);
    chk("mem_0000", {16'h0, mem[16'h0000]}, 32'h5A5A);

    // 5: error response on beat 1 of a 4-beat read
    err_addr = 16'h0021;
    err_en = 1'b1;
    t0 = cyc;
    ap(16'h0020, NS, IC, 1'b0, t0 + 1);
    ap(16'h0021, SQ, IC, 1'b0, t0 + 2);
    ev(EV_RV, 1, 16'h1111, t0 + 3);
    ev(EV_DONE, 1, 16'h1, t0 + 4);
    run_cmd(1, 16'h0020, 1'b0, 3'd4, 16'h0, 16'h0);
    repeat (3) @(negedge HCLK);
    err_en = 1'b0;

    // 6: reset during beat 2 of a 4-beat read
    t0 = cyc;
    ap(16'h0030, NS, IC, 1'b0, t0 + 1);
    ap(16'h0031, SQ, IC, 1'b0, t0 + 2);
    ap(16'h0032, SQ, IC, 1'b0, t0 + 3);
    ev(EV_RV, 0, 16'h3030, t0 + 3);
    addr[0] = 16'h0030; wr[0] = 1'b0; len[0] = 3'd4; req[0] = 1'b1;
    repeat (3) @(negedge HCLK);
    #2 RESET = 1'b0;
    req[0] = 1'b0;
    #1 rst_chk();
    @(negedge HCLK);
    RESET = 1'b1;
    repeat (5) @(negedge HCLK);
    chk("q_empty_after_reset", 32'(apq.size() + evq.size()), 0);

    // 7: len 0 treated as a single beat
    t0 = cyc;
    ap(16'h0050, NS, SG, 1'b1, t0 + 1);
    ev(EV_WACK, 1, 16'h7777, t0 + 2);
    ev(EV_DONE, 1, 16'h0, t0 + 3);
    run_cmd(1, 16'h0050, 1'b1, 3'd0, 16'h7777, 16'h0);
    repeat (2) @(negedge HCLK);
    chk("mem_0050", {16'h0, mem[16'h50]}, 32'h7777);

    // 8: len 7 clamped to 4 beats
    t0 = cyc;
    ap(16'h0003, NS, IC, 1'b0, t0 + 1);
    ap(16'h0004, SQ, IC, 1'b0, t0 + 2);
    ap(16'h0005, SQ, IC, 1'b0, t0 + 3);
    ap(16'h0006, SQ, IC, 1'b0, t0 + 4);
    ev(EV_RV, 0, 16'd40, t0 + 3);
    ev(EV_RV, 0, 16'd50, t0 + 4);
    ev(EV_RV, 0, 16'd60, t0 + 5);
    ev(EV_RV, 0, 16'h0066, t0 + 6);
    ev(EV_DONE, 0, 16'h0, t0 + 6);
    run_cmd(0, 16'h0003, 1'b0, 3'd7, 16'h0, 16'h0);

    repeat (4) @(negedge HCLK);
    chk("addr_queue_empty", 32'(apq.size()), 0);
    chk("event_queue_empty", 32'(evq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
